// File: rtl/dcache_miss_handler.sv
// Blocking single-miss service engine: optional dirty-victim writeback, line read, beat assembly, one-cycle fill.
// Optional saturating perf counters are built only when DCACHE_MISS_PERF_EN is defined; otherwise they read 0.
module dcache_miss_handler #(
    parameter  int LINE_ADDR_W = 26,
    parameter  int LINE_W      = 512,
    parameter  int BEAT_W      = 128,
    localparam int NBEATS      = LINE_W / BEAT_W,
    localparam int CNT_W       = $clog2(NBEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [LINE_ADDR_W-1:0] miss_addr,
    input  logic                   miss_dirty,
    input  logic [LINE_ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0]      victim_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [LINE_ADDR_W-1:0] mem_req_addr,
    output logic [CNT_W-1:0]       mem_req_beat,
    output logic [BEAT_W-1:0]      mem_wdata,
    input  logic                   mem_rvalid,
    input  logic [BEAT_W-1:0]      mem_rdata,
    output logic                   fill_valid,
    output logic [LINE_ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0]      fill_data,
    output logic                   busy,
    output logic [31:0]            perf_miss_cnt,
    output logic [31:0]            perf_wb_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WB_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_FILL    = 3'd4;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    logic [2:0]                    state_r;
    logic [CNT_W-1:0]              cnt_r;
    logic [LINE_ADDR_W-1:0]        miss_addr_r;
    logic [LINE_ADDR_W-1:0]        victim_addr_r;
    logic [NBEATS-1:0][BEAT_W-1:0] victim_r;
    logic [NBEATS-1:0][BEAT_W-1:0] line_r;
    logic                          accept_s;

    assign accept_s = (state_r == ST_IDLE) && miss_valid;

    // Miss FSM, request latches and read-line assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            miss_addr_r   <= '0;
            victim_addr_r <= '0;
            victim_r      <= '0;
            line_r        <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_valid) begin
                        miss_addr_r   <= miss_addr;
                        victim_addr_r <= victim_addr;
                        victim_r      <= victim_data;
                        cnt_r         <= '0;
                        state_r       <= miss_dirty ? ST_WB_REQ : ST_RD_REQ;
                    end
                end
                ST_WB_REQ: begin
                    // Counter wraps to 0 after the last beat, ready for the read phase
                    if (mem_req_ready) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_BEAT) begin
                            state_r <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_req_ready) begin
                        cnt_r   <= '0;
                        state_r <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (mem_rvalid) begin
                        line_r[cnt_r] <= mem_rdata;
                        cnt_r         <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_BEAT) begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory request fields decoded purely from registered state
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_beat  = '0;
        mem_wdata     = '0;
        case (state_r)
            ST_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = victim_addr_r;
                mem_req_beat  = cnt_r;
                mem_wdata     = victim_r[cnt_r];
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = miss_addr_r;
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

    assign miss_ready = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign fill_valid = (state_r == ST_FILL);
    assign fill_addr  = miss_addr_r;
    assign fill_data  = line_r;

`ifdef DCACHE_MISS_PERF_EN
    logic [31:0] perf_miss_r;
    logic [31:0] perf_wb_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Saturating miss and writeback event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_miss_r <= 32'd0;
            perf_wb_r   <= 32'd0;
        end else if (accept_s) begin
            perf_miss_r <= sat_inc(perf_miss_r);
            if (miss_dirty) begin
                perf_wb_r <= sat_inc(perf_wb_r);
            end
        end
    end

    assign perf_miss_cnt = perf_miss_r;
    assign perf_wb_cnt   = perf_wb_r;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
    assign perf_miss_cnt   = 32'd0;
    assign perf_wb_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Table-driven bench for dcache_miss_handler with a request/fill scoreboard and a bench-side memory model.
module tb_dcache_miss_handler;

`ifdef DCACHE_MISS_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          miss_valid;
    logic          miss_ready;
    logic [25:0]   miss_addr;
    logic          miss_dirty;
    logic [25:0]   victim_addr;
    logic [511:0]  victim_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [25:0]   mem_req_addr;
    logic [1:0]    mem_req_beat;
    logic [127:0]  mem_wdata;
    logic          mem_rvalid;
    logic [127:0]  mem_rdata;
    logic          fill_valid;
    logic [25:0]   fill_addr;
    logic [511:0]  fill_data;
    logic          busy;
    logic [31:0]   perf_miss_cnt;
    logic [31:0]   perf_wb_cnt;

    dcache_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_dirty(miss_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_beat(mem_req_beat), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .busy(busy), .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         we;
        logic [25:0]  addr;
        logic [1:0]   beat;
        logic [127:0] wdata;
    } req_t;

    typedef struct packed {
        logic [25:0]  addr;
        logic [511:0] data;
    } fill_t;

    typedef struct {
        logic [25:0]  addr;
        logic         dirty;
        logic [25:0]  vaddr;
        logic [511:0] vline;
        logic [511:0] rline;
        int           lat;
        int           stall_beat;
        int           stall_len;
        bit           stray_wb;
        bit           chain;
        int           abort;
        int           exp_fill_lat;
    } vec_t;

    req_t  req_q[$];
    fill_t fill_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_miss = 0;
    int    exp_wb = 0;
    vec_t  tbl[7];

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every presented request (held or accepted) and every fill against the queues
    task automatic sample();
        req_t  cur;
        fill_t cf;
        if (mem_req_valid === 1'b1) begin
            cur.we    = mem_req_we;
            cur.addr  = mem_req_addr;
            cur.beat  = mem_req_beat;
            cur.wdata = mem_req_we ? mem_wdata : 128'd0;
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_req actual=%0h expected=none", cur);
            end else begin
                chk("mem_req", cur, req_q[0]);
                if (mem_req_ready) void'(req_q.pop_front());
            end
        end
        if (fill_valid === 1'b1) begin
            cf.addr = fill_addr;
            cf.data = fill_data;
            if (fill_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_fill actual=%0h expected=none", cf.addr);
            end else begin
                chk("fill", cf, fill_q[0]);
                void'(fill_q.pop_front());
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        sample();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_line(input logic [127:0] b0, input logic [127:0] b1,
                                             input logic [127:0] b2, input logic [127:0] b3);
        mk_line = {b3, b2, b1, b0};
    endfunction

    task automatic chk_perf(input string tag);
        chk({tag, "_perf_miss"}, perf_miss_cnt, PERF_EN ? 32'(exp_miss) : 32'd0);
        chk({tag, "_perf_wb"}, perf_wb_cnt, PERF_EN ? 32'(exp_wb) : 32'd0);
    endtask

    task automatic run_miss(input vec_t v);
        int waits, cyc, wb_idx, stall_ctr, rd_k, lat_cnt;
        bit stray_done, done, hs, hs_we;
        req_t r;
        wb_idx = 0; stall_ctr = 0; rd_k = -1; lat_cnt = 0; stray_done = 0; done = 0; waits = 0;
        if (v.dirty) begin
            for (int i = 0; i < 4; i++) begin
                r.we = 1'b1; r.addr = v.vaddr; r.beat = 2'(i); r.wdata = v.vline[i*128 +: 128];
                req_q.push_back(r);
            end
        end
        r.we = 1'b0; r.addr = v.addr; r.beat = 2'd0; r.wdata = 128'd0;
        req_q.push_back(r);
        if (v.abort == 0) fill_q.push_back({v.addr, v.rline});
        if (v.chain) chk("miss_blocked_in_fill", miss_ready, 1'b0);
        miss_addr = v.addr; miss_dirty = v.dirty; victim_addr = v.vaddr; victim_data = v.vline;
        miss_valid = 1'b1;
        while (miss_ready !== 1'b1 && waits < 20) begin
            post();
            waits++;
        end
        chk("accept_wait", 32'(waits), v.chain ? 32'd1 : 32'd0);
        neg();
        post();
        miss_valid = 1'b0;
        exp_miss++;
        if (v.dirty) exp_wb++;
        for (cyc = 0; cyc < 200 && !done; cyc++) begin
            if (v.stall_beat >= 0 && wb_idx == v.stall_beat && stall_ctr < v.stall_len) begin
                mem_req_ready = 1'b0;
                stall_ctr++;
            end else begin
                mem_req_ready = 1'b1;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = 128'd0;
            if (rd_k >= v.lat - 1 && rd_k < v.lat + 3) begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rline[(rd_k - v.lat + 1)*128 +: 128];
            end else if (v.stray_wb && !stray_done && wb_idx == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {4{32'hDEAD_BEEF}};
                stray_done = 1'b1;
            end
            if (v.abort > 0 && rd_k == v.lat - 1 + v.abort) rst = 1'b1;
            neg();
            lat_cnt++;
            hs    = mem_req_valid && mem_req_ready;
            hs_we = mem_req_we;
            if (rst) begin
                post();
                rst = 1'b0;
                exp_miss = 0;
                exp_wb = 0;
                fill_q.delete();
                chk("abort_busy", busy, 1'b0);
                chk("abort_miss_ready", miss_ready, 1'b1);
                chk("abort_fill_valid", fill_valid, 1'b0);
                chk("abort_req_valid", mem_req_valid, 1'b0);
                chk_perf("abort");
                mem_rvalid = 1'b1;
                mem_rdata  = v.rline[3*128 +: 128];
                neg();
                post();
                mem_rvalid = 1'b0;
                repeat (4) begin
                    neg();
                    post();
                end
                chk("abort_late_beat_busy", busy, 1'b0);
                chk("abort_line_clear", fill_data, 512'd0);
                done = 1'b1;
            end else if (fill_valid) begin
                chk("fill_latency", 32'(lat_cnt), 32'(v.exp_fill_lat));
                done = 1'b1;
            end else begin
                post();
                if (hs && hs_we) wb_idx++;
                if (rd_k >= 0) rd_k++;
                if (hs && !hs_we) rd_k = 0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL miss_timeout actual=nofill expected=fill addr=%0h", v.addr);
        end
        chk("req_all_seen", 32'(req_q.size()), 32'd0);
        chk("fill_all_seen", 32'(fill_q.size()), 32'd0);
        chk_perf("miss");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{addr:26'h0000123, dirty:1'b0, vaddr:26'h0, vline:512'd0,
                   rline:mk_line(128'hA0, 128'hA1, 128'hA2, 128'hA3),
                   lat:3, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b0, abort:0, exp_fill_lat:8};
        tbl[1] = '{addr:26'h0000456, dirty:1'b1, vaddr:26'h0000055,
                   vline:mk_line(128'hD0, 128'hD1, 128'hD2, 128'hD3),
                   rline:mk_line(128'hB0, 128'hB1, 128'hB2, 128'hB3),
                   lat:3, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b0, abort:0, exp_fill_lat:12};
        tbl[2] = '{addr:26'h3FFFFFF, dirty:1'b1, vaddr:26'h2AAAAAA,
                   vline:mk_line({4{32'hC0C0_0001}}, {4{32'hC1C1_0002}}, {4{32'hC2C2_0003}}, {4{32'hC3C3_0004}}),
                   rline:mk_line({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, {4{32'h0F0F_F0F0}}, {4{32'hFFFF_0000}}),
                   lat:2, stall_beat:2, stall_len:5, stray_wb:1'b1, chain:1'b0, abort:0, exp_fill_lat:16};
        tbl[3] = '{addr:26'h0000789, dirty:1'b0, vaddr:26'h0, vline:512'd0,
                   rline:mk_line(128'h71, 128'h72, 128'h73, 128'h74),
                   lat:1, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b0, abort:0, exp_fill_lat:6};
        tbl[4] = '{addr:26'h0000ABC, dirty:1'b1, vaddr:26'h0001111,
                   vline:mk_line(128'hE0, 128'hE1, 128'hE2, 128'hE3),
                   rline:mk_line(128'hF0, 128'hF1, 128'hF2, 128'hF3),
                   lat:2, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b1, abort:0, exp_fill_lat:11};
        tbl[5] = '{addr:26'h0000321, dirty:1'b0, vaddr:26'h0, vline:512'd0,
                   rline:mk_line(128'h91, 128'h92, 128'h93, 128'h94),
                   lat:3, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b0, abort:2, exp_fill_lat:0};
        tbl[6] = '{addr:26'h0000654, dirty:1'b0, vaddr:26'h0, vline:512'd0,
                   rline:mk_line(128'h61, 128'h62, 128'h63, 128'h64),
                   lat:4, stall_beat:-1, stall_len:0, stray_wb:1'b0, chain:1'b0, abort:0, exp_fill_lat:9};

        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_dirty = 1'b0;
        victim_addr = '0; victim_data = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_we", mem_req_we, 1'b0);
        chk("rst_req_addr", mem_req_addr, 26'd0);
        chk("rst_req_beat", mem_req_beat, 2'd0);
        chk("rst_wdata", mem_wdata, 128'd0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_fill_addr", fill_addr, 26'd0);
        chk("rst_fill_data", fill_data, 512'd0);
        chk("rst_perf_miss", perf_miss_cnt, 32'd0);
        chk("rst_perf_wb", perf_wb_cnt, 32'd0);
        rst = 1'b0;
        mem_req_ready = 1'b1;

        // Stray read beat while idle must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = {4{32'h5A5A_5A5A}};
        neg();
        post();
        mem_rvalid = 1'b0;
        chk("stray_idle_busy", busy, 1'b0);
        chk("stray_idle_line", fill_data, 512'd0);
        neg();
        post();

        for (int i = 0; i < 7; i++) begin
            run_miss(tbl[i]);
            if (i < 6 && tbl[i+1].chain) continue;
            post();
            chk("idle_after_miss", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
